// File: rtl/vx_afu_ctrl_regs.sv
// AXI4-Lite control slave for the XRT AFU: kernel start/done/idle
// handshake, maskable interrupt, DCR write channel and per-bank base regs.
// Ports:
//   clk, reset        clock, async active-high reset
//   s_axi_ctrl_*      AXI4-Lite slave (AW/W/B/AR/R), OKAY responses only
//   ap_start/ap_ready/ap_done/ap_idle  kernel control handshake
//   mem_base          NUM_BANKS x 64-bit base addresses, bank i at [64i+:64]
//   dcr_wr_valid/addr/data  one-cycle DCR write strobe with payload
//   interrupt         registered level interrupt
module vx_afu_ctrl_regs #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_axi_ctrl_awvalid,
    output logic                      s_axi_ctrl_awready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_ctrl_awaddr,
    input  logic                      s_axi_ctrl_wvalid,
    output logic                      s_axi_ctrl_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
    output logic                      s_axi_ctrl_bvalid,
    input  logic                      s_axi_ctrl_bready,
    output logic [1:0]                s_axi_ctrl_bresp,
    input  logic                      s_axi_ctrl_arvalid,
    output logic                      s_axi_ctrl_arready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_ctrl_araddr,
    output logic                      s_axi_ctrl_rvalid,
    input  logic                      s_axi_ctrl_rready,
    output logic [DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
    output logic [1:0]                s_axi_ctrl_rresp,
    output logic                      ap_start,
    input  logic                      ap_ready,
    input  logic                      ap_done,
    input  logic                      ap_idle,
    output logic [NUM_BANKS*64-1:0]   mem_base,
    output logic                      dcr_wr_valid,
    output logic [31:0]               dcr_wr_addr,
    output logic [31:0]               dcr_wr_data,
    output logic                      interrupt
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("vx_afu_ctrl_regs: only DATA_WIDTH = 32 is supported");
    end

    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] A_GIE      = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] A_IER      = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] A_ISR      = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] A_DCR_ADDR = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] A_DCR_DATA = ADDR_WIDTH'('h14);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                   wstate;
    rstate_t                   rstate;
    logic                      aw_held;
    logic                      w_held;
    logic [ADDR_WIDTH-1:0]     awaddr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      rd_ctrl;

    logic                      done_s;
    logic                      ready_s;
    logic                      auto_restart;
    logic                      gie;
    logic [1:0]                ier;
    logic [1:0]                isr;
    logic [31:0]               base_lo [NUM_BANKS];
    logic [31:0]               base_hi [NUM_BANKS];

    logic                      do_write;
    logic                      wr_ctrl;
    logic                      ctrl_rd_done;
    logic [1:0]                isr_tog;
    logic [DATA_WIDTH-1:0]     rd_mux;

    function automatic logic [ADDR_WIDTH-1:0] lo_addr(input int i);
        return ADDR_WIDTH'(32 + 8 * i);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] hi_addr(input int i);
        return ADDR_WIDTH'(36 + 8 * i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign s_axi_ctrl_awready = !aw_held;
    assign s_axi_ctrl_wready  = !w_held;
    assign s_axi_ctrl_arready = (rstate == R_IDLE);
    assign s_axi_ctrl_bresp   = 2'b00;
    assign s_axi_ctrl_rresp   = 2'b00;

    // The update fires on the single cycle both beats are held in W_IDLE.
    assign do_write     = (wstate == W_IDLE) && aw_held && w_held;
    assign wr_ctrl      = do_write && (awaddr_q == A_CTRL);
    assign ctrl_rd_done = (rstate == R_DATA) && s_axi_ctrl_rready && rd_ctrl;
    assign isr_tog      = (do_write && awaddr_q == A_ISR && wstrb_q[0])
                        ? wdata_q[1:0] : 2'b00;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_base
        assign mem_base[64*g +: 64] = {base_hi[g], base_lo[g]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate            <= W_IDLE;
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            awaddr_q          <= '0;
            wdata_q           <= '0;
            wstrb_q           <= '0;
            s_axi_ctrl_bvalid <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (s_axi_ctrl_awvalid && !aw_held) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= s_axi_ctrl_awaddr;
                    end
                    if (s_axi_ctrl_wvalid && !w_held) begin
                        w_held  <= 1'b1;
                        wdata_q <= s_axi_ctrl_wdata;
                        wstrb_q <= s_axi_ctrl_wstrb;
                    end
                    if (aw_held && w_held) begin
                        wstate            <= W_RESP;
                        s_axi_ctrl_bvalid <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_ctrl_bready) begin
                        wstate            <= W_IDLE;
                        s_axi_ctrl_bvalid <= 1'b0;
                        aw_held           <= 1'b0;
                        w_held            <= 1'b0;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        if (s_axi_ctrl_araddr == A_CTRL)
            rd_mux = {24'b0, auto_restart, 3'b0,
                      ready_s, ap_idle, done_s, ap_start};
        if (s_axi_ctrl_araddr == A_GIE)      rd_mux = {31'b0, gie};
        if (s_axi_ctrl_araddr == A_IER)      rd_mux = {30'b0, ier};
        if (s_axi_ctrl_araddr == A_ISR)      rd_mux = {30'b0, isr};
        if (s_axi_ctrl_araddr == A_DCR_ADDR) rd_mux = dcr_wr_addr;
        if (s_axi_ctrl_araddr == A_DCR_DATA) rd_mux = dcr_wr_data;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (s_axi_ctrl_araddr == lo_addr(i)) rd_mux = base_lo[i];
            if (s_axi_ctrl_araddr == hi_addr(i)) rd_mux = base_hi[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate            <= R_IDLE;
            s_axi_ctrl_rvalid <= 1'b0;
            s_axi_ctrl_rdata  <= '0;
            rd_ctrl           <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axi_ctrl_arvalid) begin
                        rstate            <= R_DATA;
                        s_axi_ctrl_rvalid <= 1'b1;
                        s_axi_ctrl_rdata  <= rd_mux;
                        rd_ctrl <= (s_axi_ctrl_araddr == A_CTRL);
                    end
                end
                R_DATA: begin
                    if (s_axi_ctrl_rready) begin
                        rstate            <= R_IDLE;
                        s_axi_ctrl_rvalid <= 1'b0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ap_start     <= 1'b0;
            done_s       <= 1'b0;
            ready_s      <= 1'b0;
            auto_restart <= 1'b0;
            gie          <= 1'b0;
            ier          <= 2'b00;
            isr          <= 2'b00;
            interrupt    <= 1'b0;
            dcr_wr_valid <= 1'b0;
            dcr_wr_addr  <= '0;
            dcr_wr_data  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                base_lo[i] <= '0;
                base_hi[i] <= '0;
            end
        end else begin
            dcr_wr_valid <= do_write && (awaddr_q == A_DCR_DATA);
            if (do_write && awaddr_q == A_GIE && wstrb_q[0])
                gie <= wdata_q[0];
            if (do_write && awaddr_q == A_IER && wstrb_q[0])
                ier <= wdata_q[1:0];
            if (do_write && awaddr_q == A_DCR_ADDR)
                dcr_wr_addr <= merge(dcr_wr_addr, wdata_q, wstrb_q);
            if (do_write && awaddr_q == A_DCR_DATA)
                dcr_wr_data <= merge(dcr_wr_data, wdata_q, wstrb_q);
            if (wr_ctrl && wstrb_q[0])
                auto_restart <= wdata_q[7];
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (do_write && awaddr_q == lo_addr(i))
                    base_lo[i] <= merge(base_lo[i], wdata_q, wstrb_q);
                if (do_write && awaddr_q == hi_addr(i))
                    base_hi[i] <= merge(base_hi[i], wdata_q, wstrb_q);
            end

            // Events are ORed after the toggle so they always win.
            isr <= (isr ^ isr_tog) | ({ap_ready, ap_done} & ier);

            if (ap_done)           done_s <= 1'b1;
            else if (ctrl_rd_done) done_s <= 1'b0;
            if (ap_ready)          ready_s <= 1'b1;
            else if (ctrl_rd_done) ready_s <= 1'b0;

            if (ap_ready) ap_start <= 1'b0;
            if (auto_restart && ap_done) ap_start <= 1'b1;
            if (wr_ctrl && wstrb_q[0] && wdata_q[0] && ap_idle)
                ap_start <= 1'b1;

            interrupt <= gie & |(ier & isr);
        end
    end

endmodule
